// File: rtl/mv_pkg.sv
// Shared types for the matrix-vector result packer: frame payload, serialiser states, byte extraction.
// Checksum byte is enabled by defining MV_PACKER_CHECKSUM_EN.
package mv_pkg;

  localparam int unsigned WORD_W          = 18;
  localparam int unsigned WORDS_PER_FRAME = 4;
  localparam int unsigned BYTES_PER_WORD  = 3;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned IDX_W           = 8;
  localparam int unsigned EXT_W           = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned DATA_BYTES      = WORDS_PER_FRAME * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_IDX,
    S_DATA,
    S_CSUM
  } ser_state_t;

  typedef struct packed {
    logic [WORDS_PER_FRAME-1:0][WORD_W-1:0] words;
    logic [IDX_W-1:0]                       idx;
  } frame_t;

  // Data byte b (0..11): word b/3 sign-extended to 24 bits, MSB byte first.
  function automatic logic [BYTE_W-1:0] frame_byte(frame_t f, logic [3:0] b);
    logic [1:0]       wi;
    logic [1:0]       bi;
    logic [EXT_W-1:0] ext;
    logic [BYTE_W-1:0] res;
    wi  = 2'(b / 4'd3);
    bi  = 2'(b % 4'd3);
    ext = {{(EXT_W-WORD_W){f.words[wi][WORD_W-1]}}, f.words[wi]};
    case (bi)
      2'd0:    res = ext[23:16];
      2'd1:    res = ext[15:8];
      default: res = ext[7:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mv_frame_fifo.sv
// Synchronous FIFO of complete result frames; head entry is visible on pop_data without a read cycle.
module mv_frame_fifo
  import mv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  frame_t                       push_data,
  input  logic                         pop,
  output frame_t                       pop_data,
  output logic                         empty_c,
  output logic                         push_acc_c,
  output logic [$clog2(DEPTH):0]       count_next_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  frame_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full_c;
  logic               pop_ok_c;

  assign full_c       = (count == CNT_W'(DEPTH));
  assign empty_c      = (count == '0);
  assign pop_ok_c     = pop && !empty_c;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_acc_c   = push && (!full_c || pop_ok_c);
  assign count_next_c = count + CNT_W'(push_acc_c) - CNT_W'(pop_ok_c);
  assign pop_data     = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok_c)   rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next_c;
    end
  end

  always_ff @(posedge clock) begin
    if (push_acc_c) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mv_result_packer.sv
// Captures 4-word result groups, buffers them as frames and serialises them onto a byte link.
// Define MV_PACKER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module mv_result_packer
  import mv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ack,
  output logic              overflow,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]                             word_cnt;
  logic [IDX_W-1:0]                       frame_idx;
  logic [WORDS_PER_FRAME-1:0][WORD_W-1:0] cap_words;
  frame_t                                 push_frame;
  logic                                   push_c;
  logic                                   push_acc_c;
  logic                                   pop_c;
  logic                                   fifo_empty_c;
  frame_t                                 head_frame;
  logic [CNT_W-1:0]                       count_next_c;

  ser_state_t        state_q, state_d;
  logic [3:0]        byte_cnt_q, byte_cnt_d;
  frame_t            cur_q, cur_d;
  logic              tx_valid_d;
  logic [7:0]        tx_data_d;
  logic              busy_d;
  logic              hs_c;
  logic              last_c;
`ifdef MV_PACKER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign push_c = in_ready && (word_cnt == 2'd3);

  always_comb begin
    push_frame.words                    = cap_words;
    push_frame.words[WORDS_PER_FRAME-1] = in_data;
    push_frame.idx                      = frame_idx;
  end

  // Group capture, frame indexing and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt  <= '0;
      frame_idx <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (in_ready) begin
      word_cnt <= word_cnt + 2'd1;
      if (push_c) begin
        frame_idx <= frame_idx + IDX_W'(1);
        if (!push_acc_c) overflow <= 1'b1;
      end
    end else if (word_cnt != 2'd0) begin
      frame_err <= 1'b1;
      word_cnt  <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (in_ready && !push_c) cap_words[word_cnt] <= in_data;
  end

  mv_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (push_c),
    .push_data    (push_frame),
    .pop          (pop_c),
    .pop_data     (head_frame),
    .empty_c      (fifo_empty_c),
    .push_acc_c   (push_acc_c),
    .count_next_c (count_next_c)
  );

  assign hs_c = tx_valid && tx_ack;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    cur_d      = cur_q;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    pop_c      = 1'b0;
    last_c     = 1'b0;
`ifdef MV_PACKER_CHECKSUM_EN
    csum_d     = hs_c ? (csum_q ^ tx_data) : csum_q;
`endif
    case (state_q)
      S_IDLE: ;
      S_HDR: if (hs_c) begin
        state_d   = S_IDX;
        tx_data_d = cur_q.idx;
      end
      S_IDX: if (hs_c) begin
        state_d    = S_DATA;
        byte_cnt_d = '0;
        tx_data_d  = frame_byte(cur_q, 4'd0);
      end
      S_DATA: if (hs_c) begin
        if (byte_cnt_q == 4'(DATA_BYTES - 1)) begin
`ifdef MV_PACKER_CHECKSUM_EN
          state_d   = S_CSUM;
          tx_data_d = csum_q ^ tx_data;
`else
          last_c = 1'b1;
`endif
        end else begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          tx_data_d  = frame_byte(cur_q, byte_cnt_q + 4'd1);
        end
      end
      S_CSUM: begin
`ifdef MV_PACKER_CHECKSUM_EN
        if (hs_c) last_c = 1'b1;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (last_c) begin
      state_d    = S_IDLE;
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
    end
    // Start a frame from idle, or chain straight into the next header.
    if ((state_q == S_IDLE || last_c) && !fifo_empty_c) begin
      pop_c      = 1'b1;
      cur_d      = head_frame;
      state_d    = S_HDR;
      tx_valid_d = 1'b1;
      tx_data_d  = HDR_BYTE;
`ifdef MV_PACKER_CHECKSUM_EN
      csum_d     = '0;
`endif
    end
    busy_d = (state_d != S_IDLE) || (count_next_c != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      cur_q      <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
`ifdef MV_PACKER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      cur_q      <= cur_d;
      tx_valid   <= tx_valid_d;
      tx_data    <= tx_data_d;
      busy       <= busy_d;
`ifdef MV_PACKER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule
